// File: rtl/llc_req_dispatcher_pkg.sv
// Shared LLC request definitions: command codes, request payload and
// command classification helpers used by the dispatcher front-end.
package cache_define;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CMD_W    = 5;
    localparam int unsigned OFFSET_W = 6;
    localparam int unsigned INDEX_W  = 2;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [CMD_W-1:0] {
        READ     = 5'd0,
        WRITE    = 5'd1,
        IFETCH   = 5'd2,
        SNP_INV  = 5'd3,
        SNP_RD   = 5'd4,
        SNP_WR   = 5'd5,
        SNP_RWIM = 5'd6,
        CLEAR    = 5'd8,
        PRINT    = 5'd9
    } cmd_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } disp_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]    cmd;
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } req_t;

    function automatic logic is_snoop(input logic [CMD_W-1:0] cmd);
        return (cmd == SNP_INV) || (cmd == SNP_RD) || (cmd == SNP_WR) || (cmd == SNP_RWIM);
    endfunction

    function automatic logic is_barrier(input logic [CMD_W-1:0] cmd);
        return (cmd == CLEAR) || (cmd == PRINT);
    endfunction

    function automatic logic is_legal(input logic [CMD_W-1:0] cmd);
        return (cmd == READ) || (cmd == WRITE) || (cmd == IFETCH)
            || is_snoop(cmd) || is_barrier(cmd);
    endfunction

endpackage

// File: rtl/llc_req_dispatcher_fifo.sv
// Show-ahead in-order FIFO of req_t entries; head entry is visible
// combinationally while count is non-zero. Storage carries no reset.
module llc_req_fifo
    import cache_define::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  req_t                       wdata,
    input  logic                       pop,
    output req_t                       rdata_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == OCC_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign rdata_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/llc_req_dispatcher.sv
// LLC request front-end: filters illegal commands, queues legal requests in
// order and serialises barrier commands behind all earlier traffic.
module llc_req_dispatcher #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned INDEX_W  = 2,
    parameter int unsigned CMD_W    = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_W-1:0]              in_addr,
    input  logic [CMD_W-1:0]               in_cmd,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CMD_W-1:0]               out_cmd,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] out_tag,
    output logic [INDEX_W-1:0]             out_index,
    output logic [OFFSET_W-1:0]            out_offset,
    output logic                           out_is_snoop,
    output logic                           out_is_barrier,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic [CNT_W-1:0]               req_cnt,
    output logic [CNT_W-1:0]               illegal_cnt
);

    import cache_define::*;

    disp_state_e state;
    req_t        in_req;
    req_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        cmd_legal;
    logic        push;
    logic        pop;

    // Ready depends only on registered state, never on in_valid/out_ready.
    assign in_ready  = (state == RUN) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign cmd_legal = is_legal(in_cmd);
    assign push      = accept && cmd_legal;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    assign in_req.cmd    = in_cmd;
    assign in_req.tag    = in_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign in_req.index  = in_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign in_req.offset = in_addr[OFFSET_W-1:0];

    llc_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (in_req),
        .pop     (pop),
        .rdata_c (head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count   (occupancy)
    );

    assign out_cmd        = head.cmd;
    assign out_tag        = head.tag;
    assign out_index      = head.index;
    assign out_offset     = head.offset;
    // Flags are qualified so an empty FIFO never advertises stale contents.
    assign out_is_snoop   = out_valid && is_snoop(head.cmd);
    assign out_is_barrier = out_valid && is_barrier(head.cmd);

    // Barrier FSM plus saturating statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            req_cnt     <= '0;
            illegal_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (push && is_barrier(in_cmd)) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (pop && out_is_barrier) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
            if (pop && (req_cnt != '1)) begin
                req_cnt <= req_cnt + CNT_W'(1);
            end
            if (accept && !cmd_legal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_llc_req_dispatcher.sv
// Directed self-checking bench for llc_req_dispatcher.
module tb_llc_req_dispatcher;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [4:0]  in_cmd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_cmd;
    logic [23:0] out_tag;
    logic [1:0]  out_index;
    logic [5:0]  out_offset;
    logic        out_is_snoop;
    logic        out_is_barrier;
    logic [3:0]  occupancy;
    logic [15:0] req_cnt;
    logic [15:0] illegal_cnt;

    int vectors;
    int errors;

    llc_req_dispatcher dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_cmd         (in_cmd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_cmd        (out_cmd),
        .out_tag        (out_tag),
        .out_index      (out_index),
        .out_offset     (out_offset),
        .out_is_snoop   (out_is_snoop),
        .out_is_barrier (out_is_barrier),
        .occupancy      (occupancy),
        .req_cnt        (req_cnt),
        .illegal_cnt    (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_cmd = '0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        vectors++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        vectors++; if (req_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got %h/%h exp 0/0", req_cnt, illegal_cnt); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single_read();
        in_valid = 1'b1; in_addr = 32'h1234_5678; in_cmd = 5'd0;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL read_out_valid got %b exp 1", out_valid); end
        vectors++; if (out_tag !== 24'h123456 || out_index !== 2'd1 || out_offset !== 6'h38) begin
            errors++; $display("FAIL read_fields got %h/%0d/%h exp 123456/1/38", out_tag, out_index, out_offset); end
        vectors++; if (out_is_snoop !== 1'b0 || out_cmd !== 5'd0) begin errors++; $display("FAIL read_cmd got cmd %0d snoop %b exp 0/0", out_cmd, out_is_snoop); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (req_cnt !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL read_pop got cnt %0d valid %b exp 1/0", req_cnt, out_valid); end
    endtask

    task automatic test_full();
        logic [31:0] got;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_cmd = 5'd1; in_addr = 32'(i) * 32'h40;
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (occupancy !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state got occ %0d rdy %b exp 8/0", occupancy, in_ready); end
        in_valid = 1'b1; in_addr = 32'hDEAD_0000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++; if (occupancy !== 4'd7) begin errors++; $display("FAIL full_push_refused got occ %0d exp 7", occupancy); end
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            got = {out_tag, out_index, out_offset};
            vectors++; if (out_valid !== 1'b1 || got !== 32'(i) * 32'h40 || out_cmd !== 5'd1) begin
                errors++; $display("FAIL full_order[%0d] got %b/%h exp 1/%h", i, out_valid, got, 32'(i) * 32'h40); end
            tick();
        end
        out_ready = 1'b0;
        vectors++; if (occupancy !== 4'd0 || req_cnt !== 16'd9) begin errors++; $display("FAIL full_drain got occ %0d cnt %0d exp 0/9", occupancy, req_cnt); end
        in_valid = 1'b1; in_cmd = 5'd0; in_addr = 32'hCAFE_0040;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ninth_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        got = {out_tag, out_index, out_offset};
        vectors++; if (out_valid !== 1'b1 || got !== 32'hCAFE_0040) begin errors++; $display("FAIL ninth_accept got %b/%h exp 1/cafe0040", out_valid, got); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (req_cnt !== 16'd10) begin errors++; $display("FAIL ninth_pop got cnt %0d exp 10", req_cnt); end
    endtask

    task automatic test_illegal();
        logic [4:0] cmds [3];
        cmds[0] = 5'd7; cmds[1] = 5'd12; cmds[2] = 5'd31;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_cmd = cmds[i]; in_addr = $urandom;
            vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready[%0d] got %b exp 1", i, in_ready); end
            tick();
            vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_leak[%0d] got %b exp 0", i, out_valid); end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        vectors++; if (illegal_cnt !== 16'd3 || req_cnt !== 16'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL illegal_counts got ill %0d req %0d rdy %b exp 3/0/1", illegal_cnt, req_cnt, in_ready); end
    endtask

    task automatic test_barrier();
        logic [31:0] got;
        do_reset();
        in_valid = 1'b1;
        in_cmd = 5'd0; in_addr = 32'h100; tick();
        in_cmd = 5'd3; in_addr = 32'h200; tick();
        in_cmd = 5'd8; in_addr = 32'h000; tick();
        in_cmd = 5'd0; in_addr = 32'h300;
        vectors++; if (in_ready !== 1'b0 || occupancy !== 4'd3) begin errors++; $display("FAIL barrier_hold got rdy %b occ %0d exp 0/3", in_ready, occupancy); end
        out_ready = 1'b1;
        vectors++; if (out_cmd !== 5'd0 || out_is_barrier !== 1'b0) begin errors++; $display("FAIL barrier_head0 got %0d/%b exp 0/0", out_cmd, out_is_barrier); end
        tick();
        vectors++; if (in_ready !== 1'b0 || out_cmd !== 5'd3 || out_is_snoop !== 1'b1 || out_is_barrier !== 1'b0) begin
            errors++; $display("FAIL barrier_head1 got rdy %b cmd %0d sn %b bar %b exp 0/3/1/0", in_ready, out_cmd, out_is_snoop, out_is_barrier); end
        tick();
        vectors++; if (in_ready !== 1'b0 || out_cmd !== 5'd8 || out_is_barrier !== 1'b1) begin
            errors++; $display("FAIL barrier_head2 got rdy %b cmd %0d bar %b exp 0/8/1", in_ready, out_cmd, out_is_barrier); end
        tick();
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL barrier_release got rdy %b valid %b exp 1/0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        got = {out_tag, out_index, out_offset};
        vectors++; if (out_valid !== 1'b1 || out_cmd !== 5'd0 || got !== 32'h300 || out_is_barrier !== 1'b0) begin
            errors++; $display("FAIL barrier_after got %b/%0d/%h exp 1/0/300", out_valid, out_cmd, got); end
        tick();
        out_ready = 1'b0;
        vectors++; if (req_cnt !== 16'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL barrier_cnt got %0d/%b exp 4/0", req_cnt, out_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_cmd = 5'd1; in_addr = 32'h1000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        vectors++; if (occupancy !== 4'd5) begin errors++; $display("FAIL async_pre got occ %0d exp 5", occupancy); end
        #3 rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL async_fifo got %b/%0d exp 0/0", out_valid, occupancy); end
        vectors++; if (req_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin errors++; $display("FAIL async_cnt got %h/%h exp 0/0", req_cnt, illegal_cnt); end
        #2 rst = 1'b0;
        out_ready = 1'b0;
        tick();
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL async_run got rdy %b valid %b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_cmd = 5'd7; in_addr = 32'h0;
        repeat (65535) @(posedge clk);
        #1;
        vectors++; if (illegal_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", illegal_cnt); end
        tick();
        in_valid = 1'b0;
        vectors++; if (illegal_cnt !== 16'hFFFF || in_ready !== 1'b1) begin errors++; $display("FAIL sat_hold got %h rdy %b exp ffff/1", illegal_cnt, in_ready); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single_read();
        test_full();
        test_illegal();
        test_barrier();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/llc_req_dispatcher.md
Name: llc_req_dispatcher

Overview:
- Request front-end stage that sits directly upstream of the LLC tag/LRU lookup block (4 sets x 4 ways, 24-bit tag, 2-bit index, 6-bit byte select).
- Accepts trace requests (32-bit address plus 5-bit command) through a valid/ready handshake and filters out illegal commands.
- Buffers legal requests in an in-order FIFO and presents them to the cache pre-split into tag, index and byte-select fields.
- Serialises barrier commands (clear, print) so they never overlap in-flight traffic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_W, 32, request address width.
- OFFSET_W, 6, byte-select width (64-byte line).
- INDEX_W, 2, set-index width (4 sets).
- CMD_W, 5, command width.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Upstream request valid.
- in_ready  out  1  Dispatcher can accept a request this cycle.
- in_addr  in  ADDR_W  Request address.
- in_cmd  in  CMD_W  Request command code.
- out_valid  out  1  Head request is valid toward the cache.
- out_ready  in  1  Cache accepts the head request this cycle.
- out_cmd  out  CMD_W  Head command.
- out_tag  out  ADDR_W-INDEX_W-OFFSET_W  Head address bits [31:8].
- out_index  out  INDEX_W  Head address bits [7:6].
- out_offset  out  OFFSET_W  Head address bits [5:0].
- out_is_snoop  out  1  Head command is one of 3, 4, 5, 6.
- out_is_barrier  out  1  Head command is 8 or 9.
- occupancy  out  $clog2(DEPTH)+1  Current FIFO fill level.
- req_cnt  out  CNT_W  Requests issued to the cache; saturating.
- illegal_cnt  out  CNT_W  Requests dropped as illegal; saturating.

Behaviour:
- Command codes:
  - 0 data read, 1 data write, 2 instruction fetch.
  - 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop read-with-intent-to-modify.
  - 8 clear (barrier), 9 print (barrier).
  - All other codes (7, 10-31) are illegal.
- Input handshake:
  - A request is accepted when in_valid && in_ready.
  - in_ready = (state==RUN) && (occupancy<DEPTH). It depends on registered state only and never on in_valid or out_ready.
  - An accepted illegal command is not enqueued; illegal_cnt increments. in_ready is unchanged, so an illegal request costs one cycle.
- FIFO:
  - Show-ahead. An entry accepted at edge N drives out_valid and the out_* fields after edge N (one-cycle latency into an empty FIFO).
  - out_valid = occupancy!=0. out_* fields are a pure combinational slice of the head entry.
  - Pop on out_valid && out_ready; req_cnt increments on each pop.
  - Simultaneous push and pop: occupancy is unchanged and the order is preserved.
  - Pointers wrap modulo DEPTH.
  - A push is only allowed when not full; a same-cycle pop does not free a slot for a push.
- States:
  - RUN: normal operation. Accepting a legal barrier command enqueues it and moves to HOLD.
  - HOLD: in_ready=0. Waits for the barrier entry to be popped; on the edge where the barrier entry is popped (out_is_barrier && out_valid && out_ready), return to RUN. Entries ahead of the barrier drain normally.
  - Consequence: at most one barrier is ever in the FIFO, and it is always the youngest entry.
- Counters: saturate at all-ones and never wrap.
- Reset (asynchronous, may arrive mid-transfer):
  - Pointers, occupancy, req_cnt and illegal_cnt go to 0; state goes to RUN.
  - Outputs: out_valid=0, in_ready=1 (as soon as reset is deasserted).
  - Any in-flight or buffered requests are discarded.
- FIFO contents carry no reset; only the pointers do.

Decomposition:
- Shared package cache_define holds:
  - Command enum (READ, WRITE, IFETCH, SNP_INV, SNP_RD, SNP_WR, SNP_RWIM, CLEAR, PRINT).
  - OFFSET_W, INDEX_W, TAG_W constants.
  - Packed struct req_t {cmd, tag, index, offset}.
  - Helper functions is_legal, is_snoop, is_barrier.
- One sub-module, llc_req_fifo: a parameterised req_t show-ahead FIFO with push/pop/full/empty/count.
- The FSM, command filtering and counters live in the top-level block.

Test Plan:
- Reset, then a single read (cmd 0, address 0x1234_5678): out_valid rises one cycle later with tag=0x123456, index=1, offset=0x38, out_is_snoop=0; with out_ready=1, req_cnt=1.
- Hold out_ready=0 and push 8 writes: occupancy=8 and in_ready=0. Push and pop in the same cycle while full: the push is refused. Release out_ready: 8 pops in order; a 9th request pushed later is accepted.
- Commands 7, 12, 31 at random addresses: never appear at the output; illegal_cnt=3, req_cnt=0, in_ready stays 1.
- Sequence read, snoop invalidate (cmd 3), clear (cmd 8), read: in_ready=0 from the cycle after cmd 8 is accepted until cmd 8 is popped. The final read is issued strictly after the clear. out_is_barrier=1 only on cmd 8.
- Assert rst asynchronously between clock edges with 5 entries queued and out_ready=1: out_valid drops immediately, occupancy=0, counters=0, state returns to RUN.
- Drive illegal commands until illegal_cnt reaches 0xFFFF: the next illegal command leaves illegal_cnt at 0xFFFF.
